mem_stride_reader: RTL and testbench

Strided memory reader: on a start pulse it reads `count` words from a synchronous single-port RAM at base, base+stride, base+2·stride, … and streams them out on a valid/ready interface with a last flag. It is the read-side counterpart of the strided initialisation writer (`mem[index] = index`, step 2). It sits between a RAM read port and any downstream stream consumer, and sustains one word per cycle when the consumer never stalls.

---
 rtl/mem_stride_reader_pkg.sv | 14 +
 rtl/stream_fifo2.sv | 66 ++++++
 rtl/mem_stride_reader.sv | 151 +++++++++++++++
 tb/tb_mem_stride_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stride_reader_pkg.sv
// Shared definitions for the strided reader: FSM state encodings and default widths.
// Imported by the top level; the FIFO stays parameter-only so it can be reused elsewhere.
package mem_stride_reader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with a sideband last bit; a push into a full FIFO is taken only alongside a pop.
// Head word is registered, so output data and last stay stable until popped.
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         push_last_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         pop_last_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] dat_q  [2];
  logic         last_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   level_q;
  logic [1:0]   level_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o    = (level_q == 2'd0);
  assign full_o     = (level_q == 2'd2);
  assign pop_dat_o  = dat_q[rd_q];
  assign pop_last_o = last_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q[0]  <= '0;
      dat_q[1]  <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      level_q   <= 2'd0;
    end else begin
      if (do_push) begin
        dat_q[wr_q]  <= push_dat_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/mem_stride_reader.sv
// Strided RAM reader: streams count words from base, base+stride, ... with last on the final word.
// First word three cycles after start, one word/cycle when unstalled; reads throttle to fit a 2-entry FIFO.
module mem_stride_reader
  import mem_stride_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_e            state_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [ADDR_W-1:0] next_addr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] issued_d;
  logic [ADDR_W-1:0] accepted_q;
  logic [ADDR_W-1:0] accepted_d;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        committed;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic              final_accept;

  assign pop = out_valid & out_ready;

  // Words already held plus the one returning from RAM, less what leaves now, must leave room.
  assign occ       = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
  assign committed = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  assign issue        = (state_q == ST_RUN) && (issued_q < cnt_q) && (committed < 3'd2);
  assign issue_last   = (issued_q == cnt_q - 1'b1);
  assign final_accept = pop && (accepted_q == cnt_q - 1'b1);

  assign next_addr_d = next_addr_q + stride_q;
  assign issued_d    = issued_q + 1'b1;
  assign accepted_d  = accepted_q + 1'b1;

  assign mem_en   = issue;
  assign mem_addr = issue ? next_addr_q : last_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q         <= ST_IDLE;
      next_addr_q     <= '0;
      last_addr_q     <= '0;
      stride_q        <= '0;
      cnt_q           <= '0;
      issued_q        <= '0;
      accepted_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue & issue_last;
      if (pop) begin
        accepted_q <= accepted_d;
      end
      if (issue) begin
        last_addr_q <= next_addr_q;
      end

      case (state_q)
        ST_IDLE: begin
          // done_q high means the previous transfer is still finishing; start is ignored then.
          if (start && !done_q) begin
            if (count != '0) begin
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
              next_addr_q <= base;
              stride_q    <= stride;
              cnt_q       <= count;
              issued_q    <= '0;
              accepted_q  <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            next_addr_q <= next_addr_d;
            issued_q    <= issued_d;
            if (issue_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (final_accept) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  stream_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .push_i      (inflight_q),
    .push_dat_i  (mem_rdata),
    .push_last_i (inflight_last_q),
    .pop_i       (out_ready),
    .pop_dat_o   (out_data),
    .pop_last_o  (out_last),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_mem_stride_reader.sv
// Bench for mem_stride_reader: directed and random transfers, scoreboarded against an address/data model.
module tb_mem_stride_reader;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [7:0] base;
  logic [7:0] stride;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  mem_stride_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .base      (base),
    .stride    (stride),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 Clk = ~Clk;

  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = i[7:0];
  always @(posedge Clk) if (mem_en) mem_rdata <= ram[mem_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Reference model: expected read addresses and {last,data} words per transfer.
  logic [7:0] exp_addr_q [$];
  logic [8:0] exp_q [$];
  int c0 = 0;
  int acc_since = 0;
  int first_pop_rel = -1;
  int last_pop_rel = -1;
  int done_cnt = 0;
  int done_exp = 0;

  // Monitor / scoreboard
  int         rd_out = 0;
  logic [7:0] last_addr = '0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  always @(negedge Clk) begin : mon
    logic pop;
    logic [8:0] exp;
    if (Rst !== 1'b0) begin
      exp_q.delete();
      exp_addr_q.delete();
      rd_out = 0;
      last_addr = '0;
      prev_stall = 1'b0;
    end else begin
      pop = out_valid && out_ready;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_word", 32'({out_last, out_data}), 32'(prev_word));
      end
      prev_stall = out_valid && !out_ready;
      prev_word = {out_last, out_data};
      if (mem_en) begin
        chk("mem_en_only_busy", 32'(busy), 32'(1));
        chk("fifo_space", 32'((rd_out + 1 - int'(pop)) <= 2), 32'(1));
        if (exp_addr_q.size() == 0) fail("unexpected_read");
        else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        last_addr = mem_addr;
        rd_out++;
      end else begin
        chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
      end
      if (pop) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          exp = exp_q.pop_front();
          chk("out_word", 32'({out_last, out_data}), 32'(exp));
        end
        if (acc_since == 0) first_pop_rel = cyc - c0;
        last_pop_rel = cyc - c0;
        acc_since++;
        rd_out--;
      end
      if (done) done_cnt++;
    end
  end

  // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  int ready_mode = 0;
  int rpat = 0;
  always @(posedge Clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1: begin
        out_ready = (rpat % 4 == 0) || (rpat % 4 == 3);
        rpat++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic align();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] s, input logic [7:0] c);
    base = b;
    stride = s;
    count = c;
    start = 1'b1;
    c0 = cyc;
    acc_since = 0;
    first_pop_rel = -1;
    last_pop_rel = -1;
    for (int i = 0; i < int'(c); i++) begin
      logic [7:0] a;
      a = 8'((int'(b) + i * int'(s)) % 256);
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == int'(c) - 1), ram[a]});
    end
    done_exp++;
    align();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int rel);
    rel = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        rel = cyc - c0;
        chk("busy_at_done", 32'(busy), 32'(0));
        break;
      end
    end
    if (rel < 0) fail("done_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_mem_en"}, 32'(mem_en), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_out_last"}, 32'(out_last), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rel;
    int dbefore;
    bit reached;
    Rst = 1'b1;
    start = 1'b0;
    base = '0;
    stride = '0;
    count = '0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk_reset_outputs("reset");

    // Basic stride with cycle-exact timing
    ready_mode = 0;
    align();
    do_start(8'h00, 8'd2, 8'd5);
    chk("c1_busy", 32'(busy), 32'(1));
    chk("c1_mem_en", 32'(mem_en), 32'(1));
    chk("c1_mem_addr", 32'(mem_addr), 32'(0));
    wait_done(50, rel);
    chk("basic_done_cycle", 32'(rel), 32'(8));
    chk("basic_first_word_cycle", 32'(first_pop_rel), 32'(3));
    chk("basic_last_word_cycle", 32'(last_pop_rel), 32'(7));
    chk("basic_drained", 32'(exp_q.size()), 32'(0));

    // start coinciding with done must be ignored
    start = 1'b1;
    base = 8'h40;
    stride = 8'd1;
    count = 8'd3;
    align();
    start = 1'b0;
    repeat (4) align();
    chk("start_on_done_ignored", 32'(busy), 32'(0));

    // Wrap-around
    do_start(8'hFE, 8'd2, 8'd3);
    wait_done(50, rel);
    chk("wrap_done_cycle", 32'(rel), 32'(6));
    chk("wrap_drained", 32'(exp_q.size()), 32'(0));
    align();

    // Backpressure 1,0,0,1
    ready_mode = 1;
    rpat = 0;
    do_start(8'h10, 8'd3, 8'd6);
    wait_done(200, rel);
    chk("bp_words", 32'(acc_since), 32'(6));
    chk("bp_drained", 32'(exp_q.size()), 32'(0));
    align();

    // Zero count
    ready_mode = 0;
    do_start(8'h05, 8'd1, 8'd0);
    chk("zero_busy", 32'(busy), 32'(0));
    wait_done(10, rel);
    chk("zero_done_cycle", 32'(rel), 32'(1));
    align();

    // Start while running is ignored
    do_start(8'h20, 8'd1, 8'd5);
    align();
    start = 1'b1;
    base = 8'h80;
    stride = 8'd5;
    count = 8'd7;
    align();
    start = 1'b0;
    wait_done(50, rel);
    chk("busy_start_done_cycle", 32'(rel), 32'(8));
    chk("busy_start_words", 32'(acc_since), 32'(5));
    align();

    // Reset mid-transfer
    dbefore = done_cnt;
    do_start(8'h30, 8'd1, 8'd10);
    reached = 1'b0;
    for (int n = 0; n < 50; n++) begin
      align();
      if (acc_since >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) fail("reset_wait_4_words");
    Rst = 1'b1;
    align();
    Rst = 1'b0;
    done_exp--;
    chk_reset_outputs("midreset");
    repeat (6) align();
    chk("midreset_no_done", 32'(done_cnt), 32'(dbefore));
    chk("midreset_idle", 32'(busy), 32'(0));
    do_start(8'h01, 8'd1, 8'd2);
    wait_done(50, rel);
    chk("post_reset_done_cycle", 32'(rel), 32'(5));
    chk("post_reset_words", 32'(acc_since), 32'(2));
    align();

    // Stride 0
    do_start(8'h07, 8'd0, 8'd4);
    wait_done(50, rel);
    chk("stride0_words", 32'(acc_since), 32'(4));
    align();

    // Random transfers under random backpressure
    ready_mode = 2;
    for (int t = 0; t < 25; t++) begin
      logic [7:0] rc;
      rc = 8'($urandom_range(0, 12));
      do_start(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rc);
      wait_done(400, rel);
      chk("rand_words", 32'(acc_since), 32'(rc));
      chk("rand_drained", 32'(exp_q.size()), 32'(0));
      align();
    end

    repeat (3) align();
    chk("done_pulse_total", 32'(done_cnt), 32'(done_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
